// File: rtl/uart_rx.sv
// 8N1 serial receiver: 2-flop synchronizer, mid-bit sampling FSM, one-entry
// holding register with valid/ack handshake and sticky framing/overrun flags.
module uart_rx (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [11:0] CLKTOBAUDRATE,
  input  logic        i_uart_rx,
  output logic [7:0]  o_rx_byte,
  output logic        o_rx_valid,
  input  logic        i_rx_ack,
  output logic        o_rx_busy,
  output logic        o_frame_err,
  output logic        o_overrun,
  input  logic        i_err_clr
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t      state;
  logic [11:0] cnt;
  logic [2:0]  idx;
  logic [7:0]  shreg;
  logic        sync1;
  logic        rx_s;

  logic [11:0] half;
  logic        half_hit;
  logic        bit_hit;
  logic        complete;
  logic        frame_set;

  assign half      = {1'b0, CLKTOBAUDRATE[11:1]};
  assign half_hit  = (cnt == half - 12'd1);
  assign bit_hit   = (cnt == CLKTOBAUDRATE - 12'd1);
  assign complete  = (state == STOP) && bit_hit && rx_s;
  assign frame_set = (state == STOP) && bit_hit && !rx_s;
  assign o_rx_busy = (state != IDLE);

  // Line idles high, so the synchronizer resets to 1 to avoid a fake start bit.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= i_uart_rx;
      rx_s  <= sync1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) state <= START;
        end
        START: begin
          if (half_hit) begin
            cnt   <= '0;
            idx   <= '0;
            state <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 12'd1;
          end
        end
        DATA: begin
          if (bit_hit) begin
            shreg <= {rx_s, shreg[7:1]};
            cnt   <= '0;
            if (idx == 3'd7) state <= STOP;
            else             idx   <= idx + 3'd1;
          end else begin
            cnt <= cnt + 12'd1;
          end
        end
        STOP: begin
          if (bit_hit) begin
            cnt   <= '0;
            state <= rx_s ? IDLE : BREAK;
          end else begin
            cnt <= cnt + 12'd1;
          end
        end
        BREAK: begin
          cnt <= '0;
          if (rx_s) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          idx   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rx_byte   <= '0;
      o_rx_valid  <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      if (i_err_clr) begin
        o_frame_err <= 1'b0;
        o_overrun   <= 1'b0;
      end
      // NOTE: with non-blocking assignments the last write in the block wins,
      // so the set terms below take priority over the clear above.
      if (frame_set) o_frame_err <= 1'b1;
      if (complete) begin
        if (!o_rx_valid || i_rx_ack) begin
          o_rx_byte  <= shreg;
          o_rx_valid <= 1'b1;
        end else begin
          o_overrun <= 1'b1;
        end
      end else if (i_rx_ack && o_rx_valid) begin
        o_rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frame scenarios plus randomized
// streams checked against a queue of the bytes put on the line.
module tb_uart_rx;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [11:0] baud_div;
  logic        i_uart_rx;
  logic [7:0]  o_rx_byte;
  logic        o_rx_valid;
  logic        i_rx_ack;
  logic        o_rx_busy;
  logic        o_frame_err;
  logic        o_overrun;
  logic        i_err_clr;

  logic [11:0] obs;
  int          vectors     = 0;
  int          miscompares = 0;
  logic [7:0]  tx_q[$];

  uart_rx dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .CLKTOBAUDRATE(baud_div),
    .i_uart_rx    (i_uart_rx),
    .o_rx_byte    (o_rx_byte),
    .o_rx_valid   (o_rx_valid),
    .i_rx_ack     (i_rx_ack),
    .o_rx_busy    (o_rx_busy),
    .o_frame_err  (o_frame_err),
    .o_overrun    (o_overrun),
    .i_err_clr    (i_err_clr)
  );

  always #5 i_clk = ~i_clk;

  // Observation word: byte, valid, busy, frame_err, overrun.
  assign obs = {o_rx_byte, o_rx_valid, o_rx_busy, o_frame_err, o_overrun};

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  // Ideal transmitter: drives the first nbits of {stop, data, start}, c cycles each.
  task automatic send_frame(input logic [7:0] b, input logic stop_val,
                            input int nbits, input int c);
    logic [9:0] f;
    f = {stop_val, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      i_uart_rx = f[i];
      wait_cyc(c);
    end
  endtask

  // Streams tx_q onto the line while a consumer acks each byte and compares it.
  task automatic run_stream(input int c, input int gap_max);
    int n;
    n = tx_q.size();
    fork
      begin
        for (int i = 0; i < n; i++) begin
          send_frame(tx_q[i], 1'b1, 10, c);
          if (gap_max > 0) wait_cyc($urandom_range(gap_max, 0));
        end
      end
      begin
        for (int j = 0; j < n; j++) begin
          int t;
          t = 0;
          while (o_rx_valid !== 1'b1 && t < 30 * c + 100) begin
            @(negedge i_clk);
            t++;
          end
          vectors++;
          if (o_rx_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL stream_timeout c=%0d idx=%0d: valid=%b required 1", c, j, o_rx_valid);
            break;
          end
          vectors++;
          if (o_rx_byte !== tx_q[j]) begin
            miscompares++;
            $display("FAIL stream_byte c=%0d idx=%0d: got %h required %h", c, j, o_rx_byte, tx_q[j]);
          end
          i_rx_ack = 1'b1;
          @(negedge i_clk);
          i_rx_ack = 1'b0;
        end
      end
    join
    wait_cyc(2 * c + 8);
    vectors++;
    if (obs[3:0] !== 4'b0000) begin
      miscompares++;
      $display("FAIL stream_flags c=%0d: valid/busy/fe/ov=%b required 0000", c, obs[3:0]);
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_uart_rx = 1'b1; i_rx_ack = 1'b0; i_err_clr = 1'b0; baud_div = 12'd16;
    wait_cyc(3);
    vectors++;
    if (obs !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_values: got %h required %h", obs, 12'h000);
    end
    i_rst = 1'b0;
    wait_cyc(3);
  endtask

  task automatic test_basic();
    baud_div = 12'd16;
    // Stop sample lands 3 + 8 + 9*16 = 155 edges after the start edge is driven.
    fork
      send_frame(8'hA5, 1'b1, 10, 16);
      begin
        wait_cyc(154);
        vectors++;
        if (obs !== {8'h00, 4'b0100}) begin
          miscompares++;
          $display("FAIL basic_pre_valid: got %h required %h", obs, {8'h00, 4'b0100});
        end
        wait_cyc(1);
        vectors++;
        if (obs !== {8'hA5, 4'b1000}) begin
          miscompares++;
          $display("FAIL basic_valid_edge: got %h required %h", obs, {8'hA5, 4'b1000});
        end
      end
    join
    wait_cyc(20);
    vectors++;
    if (obs !== {8'hA5, 4'b1000}) begin
      miscompares++;
      $display("FAIL basic_held: got %h required %h", obs, {8'hA5, 4'b1000});
    end
    i_rx_ack = 1'b1;
    wait_cyc(1);
    i_rx_ack = 1'b0;
    vectors++;
    if (obs !== {8'hA5, 4'b0000}) begin
      miscompares++;
      $display("FAIL basic_ack: got %h required %h", obs, {8'hA5, 4'b0000});
    end
  endtask

  task automatic test_glitch();
    i_uart_rx = 1'b0;
    wait_cyc(3);
    i_uart_rx = 1'b1;
    wait_cyc(1);
    vectors++;
    if (obs !== {8'hA5, 4'b0100}) begin
      miscompares++;
      $display("FAIL glitch_start_seen: got %h required %h", obs, {8'hA5, 4'b0100});
    end
    wait_cyc(30);
    vectors++;
    if (obs !== {8'hA5, 4'b0000}) begin
      miscompares++;
      $display("FAIL glitch_rejected: got %h required %h", obs, {8'hA5, 4'b0000});
    end
  endtask

  task automatic test_framing();
    // Clear is pulsed in the very cycle the stop bit is sampled low: set must win.
    fork
      send_frame(8'h3C, 1'b0, 10, 16);
      begin
        wait_cyc(154);
        i_err_clr = 1'b1;
        wait_cyc(1);
        i_err_clr = 1'b0;
      end
    join
    wait_cyc(40);
    vectors++;
    if (obs !== {8'hA5, 4'b0110}) begin
      miscompares++;
      $display("FAIL framing_break: got %h required %h", obs, {8'hA5, 4'b0110});
    end
    i_uart_rx = 1'b1;
    wait_cyc(4);
    vectors++;
    if (obs !== {8'hA5, 4'b0010}) begin
      miscompares++;
      $display("FAIL framing_release: got %h required %h", obs, {8'hA5, 4'b0010});
    end
    i_err_clr = 1'b1;
    wait_cyc(1);
    i_err_clr = 1'b0;
    vectors++;
    if (obs !== {8'hA5, 4'b0000}) begin
      miscompares++;
      $display("FAIL framing_clear: got %h required %h", obs, {8'hA5, 4'b0000});
    end
  endtask

  task automatic test_overrun();
    send_frame(8'h11, 1'b1, 10, 16);
    wait_cyc(16);
    send_frame(8'h22, 1'b1, 10, 16);
    wait_cyc(16);
    vectors++;
    if (obs !== {8'h11, 4'b1001}) begin
      miscompares++;
      $display("FAIL overrun_set: got %h required %h", obs, {8'h11, 4'b1001});
    end
    i_err_clr = 1'b1;
    wait_cyc(1);
    i_err_clr = 1'b0;
    fork
      send_frame(8'h22, 1'b1, 10, 16);
      begin
        wait_cyc(154);
        i_rx_ack = 1'b1;
        wait_cyc(1);
        i_rx_ack = 1'b0;
      end
    join
    wait_cyc(16);
    vectors++;
    if (obs !== {8'h22, 4'b1000}) begin
      miscompares++;
      $display("FAIL overrun_ack_same_cycle: got %h required %h", obs, {8'h22, 4'b1000});
    end
    i_rx_ack = 1'b1;
    wait_cyc(1);
    i_rx_ack = 1'b0;
  endtask

  task automatic test_reset_midframe();
    send_frame(8'h77, 1'b1, 10, 16);
    wait_cyc(8);
    // Start plus data bits 0..3: the receiver is now waiting on data bit 4.
    send_frame(8'h5A, 1'b1, 5, 16);
    vectors++;
    if (obs !== {8'h77, 4'b1100}) begin
      miscompares++;
      $display("FAIL midframe_busy: got %h required %h", obs, {8'h77, 4'b1100});
    end
    #3 i_rst = 1'b1;
    #1;
    vectors++;
    if (obs !== 12'h000) begin
      miscompares++;
      $display("FAIL midframe_reset_async: got %h required %h", obs, 12'h000);
    end
    wait_cyc(2);
    i_uart_rx = 1'b1;
    i_rst = 1'b0;
    wait_cyc(5);
    send_frame(8'h5A, 1'b1, 10, 16);
    wait_cyc(16);
    vectors++;
    if (obs !== {8'h5A, 4'b1000}) begin
      miscompares++;
      $display("FAIL midframe_recover: got %h required %h", obs, {8'h5A, 4'b1000});
    end
    i_rx_ack = 1'b1;
    wait_cyc(1);
    i_rx_ack = 1'b0;
  endtask

  task automatic test_loopback();
    baud_div = 12'd4;
    tx_q.delete();
    for (int i = 0; i < 256; i++) tx_q.push_back(8'(i));
    run_stream(4, 0);
    baud_div = 12'd868;
    tx_q.delete();
    for (int i = 0; i < 3; i++) tx_q.push_back(8'($urandom));
    run_stream(868, 0);
  endtask

  task automatic test_random();
    int c;
    c = $urandom_range(64, 4);
    baud_div = 12'(c);
    tx_q.delete();
    for (int i = 0; i < 24; i++) tx_q.push_back(8'($urandom));
    run_stream(c, c);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_framing();
    test_overrun();
    test_reset_midframe();
    test_loopback();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
